// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream multiplexer slice.
// Select widths are derived here so every file agrees on them.
package stream_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
   localparam int   DEF_WIDTH  = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int selw(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/stream_muxn_if.sv
// Producer/consumer bundle for stream_muxn.
// slave is the mux side, master is the environment side.
import stream_pkg::*;

interface stream_muxn_if #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = 4
);

   localparam int SELW = selw(N);

   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_ch;
   logic               out_ready;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_ch
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_ch
   );

endinterface

// File: rtl/stream_muxn_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr,
// wrapping modulo N. Pointer storage lives in the caller.
module rr_arbiter
   import stream_pkg::*;
#(
   parameter  int N    = 4,
   localparam int SELW = selw(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   input  logic            en,
   output logic [SELW-1:0] gnt,
   output logic            gnt_vld
);

   logic [SELW-1:0] idx;
   logic            hit;

   always_comb begin
      gnt = '0;
      hit = 1'b0;
      idx = ptr;
      for (int k = 0; k < N; k++) begin
         // step first so ptr itself is scanned last
         if (idx >= SELW'(N - 1))
            idx = '0;
         else
            idx = idx + SELW'(1);
         if (!hit && req[idx]) begin
            gnt = idx;
            hit = 1'b1;
         end
      end
      gnt_vld = hit && en;
   end

endmodule

// File: rtl/stream_muxn.sv
// N-input stream mux with fixed-select or round-robin grant
// and a single registered output stage carrying the channel.
module stream_muxn
   import stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [selw(N)-1:0]   sel,
   stream_muxn_if.slave         bus
);

   localparam int SELW = selw(N);
   localparam int NP   = 1 << SELW;

   logic [SELW-1:0]  ptr;
   logic             ovalid;
   logic [WIDTH-1:0] odata;
   logic [SELW-1:0]  och;

   logic [NP-1:0]    vld_ext;
   logic [WIDTH-1:0] words [NP];
   logic             fx_vld;
   logic [SELW-1:0]  rr_gnt;
   logic             rr_vld;
   logic [SELW-1:0]  gnt;
   logic             gnt_vld;
   logic             load;

   // pad to a power of two so sel >= N reads zeros, never X
   assign vld_ext = NP'(bus.in_valid);

   always_comb begin
      for (int i = 0; i < NP; i++) words[i] = '0;
      for (int i = 0; i < N; i++)
         words[i] = bus.in_data[i*WIDTH +: WIDTH];
   end

   assign fx_vld = ({1'b0, sel} < (SELW + 1)'(N))
                   && vld_ext[sel];

   rr_arbiter #(.N(N)) u_arb (
      .req     (bus.in_valid),
      .ptr     (ptr),
      .en      (mode == MODE_RR),
      .gnt     (rr_gnt),
      .gnt_vld (rr_vld)
   );

   assign gnt     = (mode == MODE_RR) ? rr_gnt : sel;
   assign gnt_vld = (mode == MODE_RR) ? rr_vld : fx_vld;
   assign load    = !ovalid || bus.out_ready;

   always_comb begin
      bus.in_ready = '0;
      for (int i = 0; i < N; i++)
         if (load && gnt_vld && gnt == SELW'(i))
            bus.in_ready[i] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovalid <= 1'b0;
         odata  <= '0;
         och    <= '0;
         ptr    <= SELW'(N - 1);
      end else if (load) begin
         ovalid <= gnt_vld;
         if (gnt_vld) begin
            odata <= words[gnt];
            och   <= gnt;
            if (mode == MODE_RR) ptr <= gnt;
         end
      end
   end

   assign bus.out_valid = ovalid;
   assign bus.out_data  = odata;
   assign bus.out_ch    = och;

endmodule

// File: tb/tb_stream_muxn.sv
// Scoreboard bench for stream_muxn: directed scenarios plus
// random traffic, predicted by a plain modulo-scan model.
module tb_stream_muxn;
   import stream_pkg::*;

   localparam int W  = 8;
   localparam int N  = 4;
   localparam int SW = 2;

   typedef struct {
      int ch;
      int data;
   } exp_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          mode  = 1'b0;
   logic [SW-1:0] sel   = '0;

   stream_muxn_if #(.WIDTH(W), .N(N)) bus ();

   stream_muxn #(.WIDTH(W), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode),
      .sel   (sel),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   int   m_ptr = N - 1;
   bit   m_ov  = 1'b0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic logic [N*W-1:0] mk(input int base);
      logic [N*W-1:0] d;
      for (int i = 0; i < N; i++) d[i*W +: W] = W'(base + i);
      return d;
   endfunction

   // drive one cycle, check combinational ready, predict the edge
   task automatic cyc(input bit md, input int s,
                      input logic [N-1:0] v,
                      input logic [N*W-1:0] d,
                      input bit rdy);
      int   g;
      int   c;
      bit   ld;
      logic [N-1:0] er;
      @(posedge clk);
      #2;
      mode = md;
      sel = SW'(s);
      bus.in_valid = v;
      bus.in_data = d;
      bus.out_ready = rdy;
      #1;
      chk("out_valid", bus.out_valid, m_ov);
      g = -1;
      if (md) begin
         for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (g < 0 && v[c]) g = c;
         end
      end else if (s < N && v[s]) begin
         g = s;
      end
      ld = !m_ov || rdy;
      er = '0;
      if (ld && g >= 0) er[g] = 1'b1;
      chk("in_ready", bus.in_ready, er);
      if (ld) begin
         if (g >= 0) begin
            q.push_back('{g, int'(d[g*W +: W])});
            if (md) m_ptr = g;
         end
         m_ov = (g >= 0);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mon_empty: got ch %0d data %0h expected none",
                     bus.out_ch, bus.out_data);
         end else begin
            e = q.pop_front();
            chk("out_ch", bus.out_ch, e.ch);
            chk("out_data", bus.out_data, e.data);
         end
      end
   end

   initial begin
      logic [N*W-1:0] d;
      bus.in_valid = '0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      #3;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_ch", bus.out_ch, 0);
      #9 rst_n = 1'b1;

      d = mk(8'h10);
      d[2*W +: W] = 8'hA5;
      cyc(0, 2, 4'b1111, d, 1);
      cyc(0, 2, 4'b0000, d, 1);

      for (int i = 0; i < 5; i++) cyc(1, 0, 4'b1111, mk(8'h10), 1);
      for (int i = 0; i < 4; i++) cyc(1, 0, 4'b1010, mk(8'h20), 1);

      cyc(1, 0, 4'b0010, mk(8'h30), 1);
      for (int i = 0; i < 3; i++) cyc(1, 0, 4'b1111, mk(8'h40), 0);
      cyc(1, 0, 4'b1111, mk(8'h50), 1);

      for (int i = 0; i < 3; i++) cyc(0, 1, 4'b1101, mk(8'h60), 1);
      cyc(1, 1, 4'b1101, mk(8'h70), 1);

      for (int i = 0; i < 300; i++)
         cyc(1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
             N'($urandom), {$urandom}, $urandom_range(0, 3) != 0);

      d = mk(8'h00);
      d[1*W +: W] = 8'h3C;
      cyc(0, 1, 4'b0010, d, 1);
      @(posedge clk);
      #2;
      bus.in_valid = '0;
      chk("pre_rst_valid", bus.out_valid, 1);
      chk("pre_rst_data", bus.out_data, 8'h3C);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", bus.out_valid, 0);
      chk("async_rst_data", bus.out_data, 0);
      q.delete();
      m_ov = 1'b0;
      m_ptr = N - 1;
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cyc(1, 0, 4'b1111, mk(8'h80), 1);

      for (int i = 0; i < 200; i++)
         cyc(1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
             N'($urandom), {$urandom}, $urandom_range(0, 1) != 0);

      for (int i = 0; i < 3; i++) cyc(0, 0, 4'b0000, '0, 1);
      @(posedge clk);
      #3;
      chk("q_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
